stepper_sequencer: RTL and testbench

- Parametrised multi-channel stepper pulse generator, next generation of the three-motor step driver.
- Accepts one signed step count per channel, emits step/direction pulses at a programmable rate, and reports completion with a ready/done handshake.
- Runs entirely in the drive_clock domain: no derived clocks, no asynchronous set/clear.
- Sits between the PID/kinematics stage and the stepper driver ICs.

---
 rtl/stepper_sequencer_if.sv | 28 ++
 rtl/stepper_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_stepper_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stepper_sequencer_if.sv
// Handshake/bus bundle between the motion planner and stepper_sequencer.
// master = command side (planner), slave = sequencer side.
interface stepper_sequencer_if #(
  parameter int N_CH   = 3,
  parameter int STEP_W = 16,
  parameter int DIV_W  = 16
);
  logic [N_CH*STEP_W-1:0] steps_in;
  logic [DIV_W-1:0]       half_period;
  logic                   start;
  logic                   abort;
  logic                   ready;
  logic                   busy;
  logic                   done;
  logic                   aborted;
  logic [N_CH-1:0]        step_out;
  logic [N_CH-1:0]        step_dir;

  modport master (
    output steps_in, half_period, start, abort,
    input  ready, busy, done, aborted, step_out, step_dir
  );

  modport slave (
    input  steps_in, half_period, start, abort,
    output ready, busy, done, aborted, step_out, step_dir
  );
endinterface

// File: rtl/stepper_sequencer.sv
// Multi-channel stepper step/direction pulse generator with ready/done handshake.
// Optional macro STEP_COORD_EN selects coordinated (Bresenham) stepping across channels.
module stepper_sequencer #(
  parameter int N_CH      = 3,
  parameter int STEP_W    = 16,
  parameter int DIV_W     = 16,
  parameter int DIR_SETUP = 4
) (
  input  logic                drive_clock,
  input  logic                reset_n,
  stepper_sequencer_if.slave  bus
);
  localparam int SETUP_W = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;
  localparam logic [SETUP_W-1:0] SETUP_LOAD = SETUP_W'(DIR_SETUP - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, RUN = 2'd2, FINISH = 2'd3} state_t;

  state_t                       state_r;
  logic [N_CH-1:0][STEP_W-1:0]  mag_r, mag_s;
  logic [N_CH-1:0]              sign_s;
  logic [STEP_W-1:0]            max_r, max_s;
  logic [STEP_W-1:0]            period_r, period_next_s;
  logic [DIV_W-1:0]             half_r, phase_cnt_r;
  logic [SETUP_W-1:0]           setup_cnt_r;
  logic                         phase_high_r;
  logic [N_CH-1:0]              step_next_s;
  logic                         ready_r, busy_r, done_r, aborted_r;
  logic [N_CH-1:0]              step_out_r, step_dir_r;

  assign bus.ready    = ready_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.aborted  = aborted_r;
  assign bus.step_out = step_out_r;
  assign bus.step_dir = step_dir_r;

  // Magnitudes, signs and largest magnitude of the offered counts; -2^(STEP_W-1) maps to 2^(STEP_W-1).
  always_comb begin
    max_s  = '0;
    mag_s  = '0;
    sign_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      sign_s[i] = bus.steps_in[i*STEP_W + STEP_W - 1];
      if (sign_s[i]) begin
        mag_s[i] = STEP_W'(0) - bus.steps_in[i*STEP_W +: STEP_W];
      end else begin
        mag_s[i] = bus.steps_in[i*STEP_W +: STEP_W];
      end
      if (mag_s[i] > max_s) begin
        max_s = mag_s[i];
      end else begin
        max_s = max_s;
      end
    end
  end

  // Index of the period about to begin.
  always_comb begin
    case (state_r)
      SETUP:   period_next_s = '0;
      RUN:     period_next_s = period_r + STEP_W'(1);
      default: period_next_s = '0;
    endcase
  end

`ifdef STEP_COORD_EN
  logic [N_CH-1:0][STEP_W:0] acc_r, acc_sum_s, acc_next_s;
  logic                      period_start_s;

  assign period_start_s = !bus.abort &&
                          (((state_r == SETUP) && (setup_cnt_r == '0)) ||
                           ((state_r == RUN) && (phase_cnt_r == '0) && !phase_high_r &&
                            (period_r != max_r - STEP_W'(1))));

  // Bresenham decision: step whenever the accumulator reaches the longest move.
  always_comb begin
    acc_sum_s   = '0;
    acc_next_s  = '0;
    step_next_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      acc_sum_s[i] = acc_r[i] + {1'b0, mag_r[i]};
      if (acc_sum_s[i] >= {1'b0, max_r}) begin
        step_next_s[i] = 1'b1;
        acc_next_s[i]  = acc_sum_s[i] - {1'b0, max_r};
      end else begin
        step_next_s[i] = 1'b0;
        acc_next_s[i]  = acc_sum_s[i];
      end
    end
  end

  // Accumulators advance once per period and restart with each accepted move.
  always_ff @(posedge drive_clock) begin
    if (!reset_n) begin
      acc_r <= '0;
    end else if ((state_r == IDLE) && bus.start) begin
      acc_r <= '0;
    end else if (period_start_s) begin
      acc_r <= acc_next_s;
    end else begin
      acc_r <= acc_r;
    end
  end
`else
  // Independent stepping: a channel pulses in its first m_i periods only.
  always_comb begin
    step_next_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (period_next_s < mag_r[i]) begin
        step_next_s[i] = 1'b1;
      end else begin
        step_next_s[i] = 1'b0;
      end
    end
  end
`endif

  // Move sequencer with registered handshake and pulse outputs.
  always_ff @(posedge drive_clock) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      mag_r        <= '0;
      max_r        <= '0;
      period_r     <= '0;
      half_r       <= '0;
      phase_cnt_r  <= '0;
      setup_cnt_r  <= '0;
      phase_high_r <= 1'b0;
      ready_r      <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      aborted_r    <= 1'b0;
      step_out_r   <= '0;
      step_dir_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            mag_r       <= mag_s;
            max_r       <= max_s;
            step_dir_r  <= sign_s;
            half_r      <= (bus.half_period == '0) ? DIV_W'(1) : bus.half_period;
            period_r    <= '0;
            setup_cnt_r <= SETUP_LOAD;
            ready_r     <= 1'b0;
            busy_r      <= 1'b1;
            if (max_s == '0) begin
              state_r   <= FINISH;
              done_r    <= 1'b1;
              aborted_r <= 1'b0;
            end else begin
              state_r <= SETUP;
            end
          end
        end
        SETUP: begin
          if (bus.abort) begin
            state_r    <= FINISH;
            step_out_r <= '0;
            done_r     <= 1'b1;
            aborted_r  <= 1'b1;
          end else if (setup_cnt_r == '0) begin
            state_r      <= RUN;
            period_r     <= period_next_s;
            step_out_r   <= step_next_s;
            phase_high_r <= 1'b1;
            phase_cnt_r  <= half_r - DIV_W'(1);
          end else begin
            setup_cnt_r <= setup_cnt_r - SETUP_W'(1);
          end
        end
        RUN: begin
          if (bus.abort) begin
            state_r    <= FINISH;
            step_out_r <= '0;
            done_r     <= 1'b1;
            aborted_r  <= 1'b1;
          end else if (phase_cnt_r != '0) begin
            phase_cnt_r <= phase_cnt_r - DIV_W'(1);
          end else if (phase_high_r) begin
            step_out_r   <= '0;
            phase_high_r <= 1'b0;
            phase_cnt_r  <= half_r - DIV_W'(1);
          end else if (period_r == max_r - STEP_W'(1)) begin
            state_r   <= FINISH;
            done_r    <= 1'b1;
            aborted_r <= 1'b0;
          end else begin
            period_r     <= period_next_s;
            step_out_r   <= step_next_s;
            phase_high_r <= 1'b1;
            phase_cnt_r  <= half_r - DIV_W'(1);
          end
        end
        FINISH: begin
          state_r   <= IDLE;
          ready_r   <= 1'b1;
          busy_r    <= 1'b0;
          aborted_r <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          ready_r    <= 1'b1;
          busy_r     <= 1'b0;
          aborted_r  <= 1'b0;
          step_out_r <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_stepper_sequencer.sv
// Self-checking bench for stepper_sequencer: vector table plus hand-written
// reset/abort/full-range sequences, with a scoreboard of expected step/done events.
module tb_stepper_sequencer;
  localparam int N_CH = 3;
  localparam int STEP_W = 16;
  localparam int DIV_W = 16;
  localparam int DS = 4;

  typedef struct {
    int s0;
    int s1;
    int s2;
    int h;
    int abort_at;
    logic [2:0] exp_dir;
    int exp_len;
  } vec_t;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;

  logic drive_clock = 1'b0;
  logic reset_n = 1'b0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  ev_t sb_q[$];
  logic [N_CH-1:0] prev_so = '0;
  bit count_mode = 1'b0;
  int pulse_cnt = 0;
  int big_done_cyc = -1;
  int big_done_ab = -1;
  vec_t vecs[9];

  stepper_sequencer_if #(.N_CH(N_CH), .STEP_W(STEP_W), .DIV_W(DIV_W)) bus ();

  stepper_sequencer #(.N_CH(N_CH), .STEP_W(STEP_W), .DIV_W(DIV_W), .DIR_SETUP(DS)) dut (
    .drive_clock (drive_clock),
    .reset_n     (reset_n),
    .bus         (bus)
  );

  always #5 drive_clock = ~drive_clock;

  always @(posedge drive_clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_event(input int kind, input int val);
    ev_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d at cycle %0d, required none", kind, val, cyc);
    end else begin
      e = sb_q.pop_front();
      if (e.cyc != cyc || e.kind != kind || e.val != val) begin
        errors++;
        $display("FAIL event: got kind=%0d val=%0d cycle=%0d, required kind=%0d val=%0d cycle=%0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  // kind 0 = rising step edge (val = channel), kind 1 = done pulse (val = aborted)
  task automatic monitor();
    logic [N_CH-1:0] so;
    so = bus.step_out;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (so[ch] && !prev_so[ch]) begin
        if (count_mode) begin
          if (ch == 0) pulse_cnt++;
          else check("spurious_edge", 32'(ch), 32'(0));
        end else begin
          expect_event(0, ch);
        end
      end
    end
    if (bus.done) begin
      if (count_mode) begin
        big_done_cyc = cyc;
        big_done_ab = int'(bus.aborted);
      end else begin
        expect_event(1, int'(bus.aborted));
      end
    end
    prev_so = so;
  endtask

  task automatic tick();
    @(negedge drive_clock);
    monitor();
  endtask

  // Reference timeline built from the counts and half period alone.
  task automatic push_expected(input int k, input vec_t v);
    int sv[3];
    int m[3];
    int acc[3];
    int mx;
    int hh;
    int rc;
    bit st;
    ev_t e;
    sv[0] = v.s0; sv[1] = v.s1; sv[2] = v.s2;
    mx = 0;
    for (int i = 0; i < 3; i++) begin
      m[i] = (sv[i] < 0) ? -sv[i] : sv[i];
      acc[i] = 0;
      if (m[i] > mx) mx = m[i];
    end
    hh = (v.h == 0) ? 1 : v.h;
    if (mx > 0) begin
      for (int p = 0; p < mx; p++) begin
        for (int i = 0; i < 3; i++) begin
`ifdef STEP_COORD_EN
          acc[i] += m[i];
          st = (acc[i] >= mx);
          if (st) acc[i] -= mx;
`else
          st = (p < m[i]);
`endif
          rc = k + 1 + DS + 2 * p * hh;
          if (st && (v.abort_at < 0 || rc <= k + v.abort_at)) begin
            e.cyc = rc; e.kind = 0; e.val = i;
            sb_q.push_back(e);
          end
        end
      end
    end
    e.kind = 1;
    if (v.abort_at >= 0) begin
      e.cyc = k + v.abort_at + 1; e.val = 1;
    end else if (mx == 0) begin
      e.cyc = k + 1; e.val = 0;
    end else begin
      e.cyc = k + 1 + DS + 2 * mx * hh; e.val = 0;
    end
    sb_q.push_back(e);
  endtask

  task automatic drive_start(input vec_t v, input logic abort_too);
    bus.steps_in = {16'(v.s2), 16'(v.s1), 16'(v.s0)};
    bus.half_period = 16'(v.h);
    bus.start = 1'b1;
    bus.abort = abort_too;
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    k = cyc;
    drive_start(v, (v.abort_at < 0) ? 1'b1 : 1'b0);
    push_expected(k, v);
    for (int t = 1; t <= v.exp_len + 1; t++) begin
      tick();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (t == 1) begin
        check("accept_ready", 32'(bus.ready), 32'(0));
        check("accept_busy", 32'(bus.busy), 32'(1));
        check("accept_dir", 32'(bus.step_dir), 32'(v.exp_dir));
        bus.steps_in = {16'($urandom), 16'($urandom), 16'($urandom)};
        bus.half_period = 16'($urandom_range(0, 7));
        bus.start = 1'b1;
      end
      if (t == 3 && v.exp_len > 4) bus.start = 1'b1;
      if (t == v.abort_at) bus.abort = 1'b1;
      if (v.abort_at > 0 && t == v.abort_at + 1) check("abort_step_low", 32'(bus.step_out), 32'(0));
      if (t == v.exp_len) begin
        check("done_pulse", 32'(bus.done), 32'(1));
        bus.abort = 1'b1;
      end
      if (t == v.exp_len + 1) begin
        check("end_ready", 32'(bus.ready), 32'(1));
        check("end_busy", 32'(bus.busy), 32'(0));
        check("end_done_low", 32'(bus.done), 32'(0));
        check("end_aborted_low", 32'(bus.aborted), 32'(0));
        check("dir_stable", 32'(bus.step_dir), 32'(v.exp_dir));
      end
    end
    bus.abort = 1'b0;
    check("sb_empty", 32'(sb_q.size()), 32'(0));
    sb_q.delete();
    tick();
  endtask

  initial begin
    vec_t v;
    int k;
    vecs[0] = '{3, -2, 0, 2, -1, 3'b010, 17};
    vecs[1] = '{0, 0, 0, 5, -1, 3'b000, 1};
    vecs[2] = '{1, 1, 1, 1, -1, 3'b000, 7};
    vecs[3] = '{-1, 5, -3, 3, -1, 3'b101, 35};
    vecs[4] = '{2, 0, -4, 0, -1, 3'b100, 13};
    vecs[5] = '{4, 2, 1, 1, -1, 3'b000, 13};
    vecs[6] = '{6, 1, 2, 3, 6, 3'b000, 7};
    vecs[7] = '{2, 2, 2, 1, 2, 3'b000, 3};
    vecs[8] = '{1, -1, 1, 20, -1, 3'b010, 45};

    bus.steps_in = '0;
    bus.half_period = '0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    tick();
    tick();
    check("rst_ready", 32'(bus.ready), 32'(1));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_aborted", 32'(bus.aborted), 32'(0));
    check("rst_step_out", 32'(bus.step_out), 32'(0));
    check("rst_step_dir", 32'(bus.step_dir), 32'(0));
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset mid-RUN while ch0 is high: everything returns to reset values, no done.
    v = vecs[0];
    k = cyc;
    drive_start(v, 1'b0);
    push_expected(k, v);
    for (int t = 1; t <= 6; t++) begin
      tick();
      bus.start = 1'b0;
    end
    check("pre_reset_high", 32'(bus.step_out[0]), 32'(1));
    reset_n = 1'b0;
    sb_q.delete();
    tick();
    check("midrst_step_out", 32'(bus.step_out), 32'(0));
    check("midrst_busy", 32'(bus.busy), 32'(0));
    check("midrst_ready", 32'(bus.ready), 32'(1));
    check("midrst_dir", 32'(bus.step_dir), 32'(0));
    check("midrst_done", 32'(bus.done), 32'(0));
    reset_n = 1'b1;
    for (int t = 0; t < 4; t++) tick();
    run_vec(vecs[0]);

    // Full-range negative count with H=0: 32768 pulses on ch0, H=1 timing.
    count_mode = 1'b1;
    pulse_cnt = 0;
    k = cyc;
    bus.steps_in = {16'(0), 16'(0), 16'h8000};
    bus.half_period = 16'(0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("big_dir", 32'(bus.step_dir), 32'(3'b001));
    for (int t = 2; t <= 65542 && big_done_cyc < 0; t++) tick();
    tick();
    check("big_pulses", 32'(pulse_cnt), 32'(32768));
    check("big_done_cycle", 32'(big_done_cyc - k), 32'(1 + DS + 65536));
    check("big_done_aborted", 32'(big_done_ab), 32'(0));
    check("big_ready", 32'(bus.ready), 32'(1));
    count_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
